// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: pc_op encodings, fetch state enum
// and opcode field width.
package cpu_pkg;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_BRF  = 2'b10;
    localparam logic [1:0] PC_JMP  = 2'b11;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_FETCH = 2'b01,
        FS_DONE  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection from (pc, op, flag, target); increment
// wraps modulo 2^ADDR_W.
module pc_next_logic
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        op,
    input  logic              flag,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        pc_next = pc;
        case (op)
            PC_INC:  pc_next = pc_inc;
            PC_BRF:  pc_next = flag ? target : pc_inc;
            PC_JMP:  pc_next = target;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter plus instruction fetch over a req/valid handshake.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state    | meaning
// FS_IDLE  | no fetch outstanding; pc_op applied directly, inst_wr starts a fetch
// FS_FETCH | imem_req held until imem_valid (or watchdog expiry); pc_op parked
// FS_DONE  | instruction register just loaded, inst_valid high; pc update applied
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 8,
    parameter int unsigned       INST_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter logic [INST_W-1:0] NOP_WORD       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          pc_op,
    input  logic                flag,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                inst_wr,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_req,
    input  logic [INST_W-1:0]   imem_data,
    input  logic                imem_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [INST_W-1:0]   instruction,
    output logic [OPCODE_W-1:0] opcode,
    output logic                inst_valid,
    output logic                fetch_busy,
    output logic                fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [INST_W-1:0] instruction_q, instruction_d;
    logic              imem_req_q, imem_req_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fetch_busy_q, fetch_busy_d;

    // Pending op register; PC_HOLD doubles as "nothing pending".
    logic [1:0]        pend_op_q, pend_op_d;
    logic              pend_flag_q, pend_flag_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic [1:0]        sel_op;
    logic              sel_flag;
    logic [ADDR_W-1:0] sel_target;
    logic [ADDR_W-1:0] pc_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             fetch_err_q, fetch_err_d;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYCLES;
`endif

    // A non-hold op arriving in DONE overrides the parked one.
    always_comb begin
        if ((state_q == FS_DONE) && (pc_op == PC_HOLD)) begin
            sel_op     = pend_op_q;
            sel_flag   = pend_flag_q;
            sel_target = pend_target_q;
        end else begin
            sel_op     = pc_op;
            sel_flag   = flag;
            sel_target = branch_target;
        end
    end

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc      (pc_q),
        .op      (sel_op),
        .flag    (sel_flag),
        .target  (sel_target),
        .pc_next (pc_next)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_addr_d   = imem_addr_q;
        instruction_d = instruction_q;
        imem_req_d    = imem_req_q;
        pend_op_d     = pend_op_q;
        pend_flag_d   = pend_flag_q;
        pend_target_d = pend_target_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        fetch_err_d   = fetch_err_q;
`endif
        case (state_q)
            FS_IDLE: begin
                pc_d = pc_next;
                if (inst_wr) begin
                    imem_addr_d = pc_q;
                    imem_req_d  = 1'b1;
                    state_d     = FS_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d   = TMO_LOAD;
`endif
                end
            end
            FS_FETCH: begin
                if (pc_op != PC_HOLD) begin
                    pend_op_d     = pc_op;
                    pend_flag_d   = flag;
                    pend_target_d = branch_target;
                end
                if (imem_valid) begin
                    instruction_d = imem_data;
                    imem_req_d    = 1'b0;
                    state_d       = FS_DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    instruction_d = NOP_WORD;
                    imem_req_d    = 1'b0;
                    fetch_err_d   = 1'b1;
                    state_d       = FS_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                end
`endif
            end
            FS_DONE: begin
                pc_d      = pc_next;
                pend_op_d = PC_HOLD;
                state_d   = FS_IDLE;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
        inst_valid_d = (state_d == FS_DONE);
        fetch_busy_d = (state_d != FS_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            imem_addr_q   <= RESET_PC;
            instruction_q <= NOP_WORD;
            imem_req_q    <= 1'b0;
            inst_valid_q  <= 1'b0;
            fetch_busy_q  <= 1'b0;
            pend_op_q     <= PC_HOLD;
            pend_flag_q   <= 1'b0;
            pend_target_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            instruction_q <= instruction_d;
            imem_req_q    <= imem_req_d;
            inst_valid_q  <= inst_valid_d;
            fetch_busy_q  <= fetch_busy_d;
            pend_op_q     <= pend_op_d;
            pend_flag_q   <= pend_flag_d;
            pend_target_q <= pend_target_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            fetch_err_q   <= fetch_err_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = imem_addr_q;
    assign imem_req    = imem_req_q;
    assign instruction = instruction_q;
    assign opcode      = instruction_q[INST_W-1 -: OPCODE_W];
    assign inst_valid  = inst_valid_q;
    assign fetch_busy  = fetch_busy_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = fetch_err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed cases plus randomized
// traffic compared each cycle against a behavioural model.
module tb_fetch_pc_unit;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pc_op = 2'b00;
    logic        flag = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        inst_wr = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_valid = 1'b0;
    logic [7:0]  pc;
    logic [15:0] instruction;
    logic [3:0]  opcode;
    logic        inst_valid;
    logic        fetch_busy;
    logic        fetch_err;

    fetch_pc_unit dut (
        .clock         (clock),
        .reset         (reset),
        .pc_op         (pc_op),
        .flag          (flag),
        .branch_target (branch_target),
        .inst_wr       (inst_wr),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_data     (imem_data),
        .imem_valid    (imem_valid),
        .pc            (pc),
        .instruction   (instruction),
        .opcode        (opcode),
        .inst_valid    (inst_valid),
        .fetch_busy    (fetch_busy),
        .fetch_err     (fetch_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents and memory responder knobs
    logic [15:0] mem [256];
    int  mem_lat = 0;
    int  mem_left = 0;
    bit  mem_busy = 1'b0;
    bit  noise_en = 1'b0;

    // Behavioural model state
    logic [7:0]  pc_m = 8'h00;
    logic [15:0] instr_m = 16'h0000;
    logic [7:0]  addr_m = 8'h00;
    bit          req_m = 1'b0;
    bit          iv_m = 1'b0;
    bit          err_m = 1'b0;
    int          pend_op_m = 0;
    bit          pend_flag_m = 1'b0;
    logic [7:0]  pend_tgt_m = 8'h00;
    int          waited_m = 0;

    function automatic logic [7:0] npc(input logic [7:0] p, input int op, input bit f, input logic [7:0] t);
        int inc;
        inc = (int'(p) + 1) % 256;
        case (op)
            1:       return 8'(inc);
            2:       return f ? t : 8'(inc);
            3:       return t;
            default: return p;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            pc_m = 8'h00; instr_m = 16'h0000; addr_m = 8'h00;
            req_m = 1'b0; iv_m = 1'b0; err_m = 1'b0;
            pend_op_m = 0; waited_m = 0;
        end else if (iv_m) begin
            if (pc_op != 2'b00)
                pc_m = npc(pc_m, int'(pc_op), flag, branch_target);
            else if (pend_op_m != 0)
                pc_m = npc(pc_m, pend_op_m, pend_flag_m, pend_tgt_m);
            pend_op_m = 0;
            iv_m = 1'b0;
        end else if (req_m) begin
            if (pc_op != 2'b00) begin
                pend_op_m = int'(pc_op); pend_flag_m = flag; pend_tgt_m = branch_target;
            end
            waited_m++;
            if (imem_valid) begin
                instr_m = mem[addr_m]; req_m = 1'b0; iv_m = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (waited_m == TMO) begin
                instr_m = 16'h0000; req_m = 1'b0; iv_m = 1'b1; err_m = 1'b1;
            end
`endif
        end else begin
            if (inst_wr) begin
                addr_m = pc_m; req_m = 1'b1; waited_m = 0;
            end
            pc_m = npc(pc_m, int'(pc_op), flag, branch_target);
        end
    end

    // Memory responder: answers mem_lat cycles after the request is seen
    always @(negedge clock) begin
        if (req_m) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_left = mem_lat;
            end
            if (mem_left == 0) begin
                imem_valid = 1'b1;
            end else begin
                imem_valid = 1'b0;
                mem_left--;
            end
        end else begin
            mem_busy = 1'b0;
            imem_valid = noise_en ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
        imem_data = mem[imem_addr];
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("pc", 32'(pc), 32'(pc_m));
            chk("instruction", 32'(instruction), 32'(instr_m));
            chk("opcode", 32'(opcode), 32'(instr_m[15:12]));
            chk("imem_req", 32'(imem_req), 32'(req_m));
            if (req_m) chk("imem_addr", 32'(imem_addr), 32'(addr_m));
            chk("inst_valid", 32'(inst_valid), 32'(iv_m));
            chk("fetch_busy", 32'(fetch_busy), 32'(req_m | iv_m));
            chk("fetch_err", 32'(fetch_err), 32'(err_m));
        end
    end

    task automatic drive(input logic [1:0] op, input logic f, input logic [7:0] t, input logic wr);
        pc_op = op; flag = f; branch_target = t; inst_wr = wr;
        @(posedge clock);
        @(negedge clock);
        pc_op = 2'b00; inst_wr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h05] = 16'h3A12;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state after idling
        repeat (5) drive(2'b00, 1'b0, 8'h00, 1'b0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_instruction", 32'(instruction), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'h0);

        // Zero-wait fetch at pc=0x05
        drive(2'b11, 1'b0, 8'h05, 1'b0);
        mem_lat = 0;
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        chk("zw_req_n1", 32'(imem_req), 32'h1);
        chk("zw_addr_n1", 32'(imem_addr), 32'h05);
        chk("zw_iv_n1", 32'(inst_valid), 32'h0);
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        chk("zw_iv_n2", 32'(inst_valid), 32'h1);
        chk("zw_opcode", 32'(opcode), 32'h3);
        chk("zw_instruction", 32'(instruction), 32'h3A12);
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        chk("zw_iv_n3", 32'(inst_valid), 32'h0);

        // Next-PC rules and wrap
        drive(2'b11, 1'b0, 8'hFF, 1'b0);
        chk("jmp_ff", 32'(pc), 32'hFF);
        drive(2'b01, 1'b0, 8'h00, 1'b0);
        chk("inc_wrap", 32'(pc), 32'h00);
        drive(2'b10, 1'b0, 8'h40, 1'b0);
        chk("brf_not_taken", 32'(pc), 32'h01);
        drive(2'b10, 1'b1, 8'h40, 1'b0);
        chk("brf_taken", 32'(pc), 32'h40);
        drive(2'b11, 1'b0, 8'h07, 1'b0);
        chk("jmp_07", 32'(pc), 32'h07);

        // Slow memory with ops parked during FETCH; last one wins
        mem_lat = 4;
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        drive(2'b11, 1'b0, 8'h20, 1'b0);
        chk("pend_hold1", 32'(pc), 32'h07);
        drive(2'b01, 1'b0, 8'h00, 1'b0);
        chk("pend_hold2", 32'(pc), 32'h07);
        k = 0;
        while (!inst_valid && k < 20) begin
            drive(2'b00, 1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("pend_done_seen", 32'(inst_valid), 32'h1);
        chk("pend_pc_at_done", 32'(pc), 32'h07);
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        chk("pend_applied", 32'(pc), 32'h08);

        // inst_wr and pc_op in the same cycle
        drive(2'b11, 1'b0, 8'h10, 1'b0);
        mem_lat = 0;
        drive(2'b01, 1'b0, 8'h00, 1'b1);
        chk("same_cyc_addr", 32'(imem_addr), 32'h10);
        chk("same_cyc_pc", 32'(pc), 32'h11);
        repeat (3) drive(2'b00, 1'b0, 8'h00, 1'b0);

        // Reset mid-fetch
        mem_lat = 6;
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        chk("rstmid_req", 32'(imem_req), 32'h0);
        chk("rstmid_busy", 32'(fetch_busy), 32'h0);
        repeat (8) drive(2'b00, 1'b0, 8'h00, 1'b0);
        chk("rstmid_no_late_iv", 32'(inst_valid), 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // Watchdog expiry
        mem_lat = 1000;
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        k = 0;
        while (imem_req && k < 40) begin
            k++;
            drive(2'b00, 1'b0, 8'h00, 1'b0);
        end
        chk("tmo_req_cycles", 32'(k), 32'(TMO));
        chk("tmo_iv", 32'(inst_valid), 32'h1);
        chk("tmo_instruction", 32'(instruction), 32'h0);
        chk("tmo_err", 32'(fetch_err), 32'h1);
        mem_lat = 0;
        repeat (3) drive(2'b00, 1'b0, 8'h00, 1'b0);
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(2'b00, 1'b0, 8'h00, 1'b0);
        chk("tmo_err_sticky", 32'(fetch_err), 32'h1);
        mem_lat = 1000;
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        drive(2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        chk("tmo_rst_req", 32'(imem_req), 32'h0);
        chk("tmo_rst_err", 32'(fetch_err), 32'h0);
        mem_lat = 0;
`endif

        // Randomized traffic, checked every cycle by the compare process
        noise_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            mem_lat = $urandom_range(0, 4);
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        end
        reset = 1'b0;
        noise_en = 1'b0;
        repeat (4) drive(2'b00, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
